pong_game_state: RTL and testbench
==================================

Name: pong_game_state

Overview:
Per-frame game datapath for VGA Pong. It sits directly upstream of the pixel renderer and feeds it paddle centres, ball centre and both scores. It is advanced once per video frame by a tick from the sync generator. Its inputs are debounced NES controller button levels from the controller readers.

Parameters:
PADDLE_SPEED, 4, paddle pixels moved per frame
BALL_SPEED, 2, ball pixels moved per frame on each axis
SERVE_FRAMES, 60, frames held in SERVE before ball launches
WIN_SCORE, 9, score that ends the game

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse per frame, asserted outside active video
left_up  input  1  left player up button, level, active-high
left_down  input  1  left player down button
right_up  input  1  right player up button
right_down  input  1  right player down button
start  input  1  either player's Start button, OR'd upstream
leftPaddle  output  10  left paddle centre row
rightPaddle  output  10  right paddle centre row
ball_center_x  output  10  ball centre column
ball_center_y  output  10  ball centre row
scoreLeft  output  4  left score, 0..9
scoreRight  output  4  right score, 0..9
game_over  output  1  high while in GAME_OVER

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high and wins over everything, including a coincident frame_tick.
- Reset values: paddles = 220; ball = (320,220); scores = 0; game_over = 0; state = SERVE; serve counter = 0; ball direction dx = +1, dy = +1.
- Update timing: all state changes only on a cycle with frame_tick=1. Outputs are registered and take new values the cycle after the tick. Outputs are held otherwise.
- Geometry (fixed):
  - Field border rows 20/420, columns 20/620.
  - Left paddle face column 43; right paddle face column 597.
  - Paddle half-length 25; ball radius 4.
- Paddles:
  - up-only: centre -= PADDLE_SPEED. down-only: centre += PADDLE_SPEED. Both or neither: hold.
  - Clamp to 46..394 by saturating, never wrapping.
  - Paddles move in every state except GAME_OVER.
- States:
  - SERVE: ball held at (320,220). Counter increments per tick; at SERVE_FRAMES-1 clear the counter and go to PLAY.
  - PLAY: move ball each tick. nx = x ± BALL_SPEED, ny = y ± BALL_SPEED, computed with an 11-bit intermediate and no underflow.
  - POINT: 1 tick, which updates the score. If the new score equals WIN_SCORE go to GAME_OVER, else go to SERVE.
  - GAME_OVER: game_over=1; ball parked at (320,220); paddles frozen. A tick with start=1 clears the scores, recentres the paddles and goes to SERVE.
- Vertical in PLAY:
  - If ny <= 25: y = 25, dy = +1.
  - Else if ny >= 415: y = 415, dy = -1.
- Horizontal in PLAY (priority over vertical, evaluated the same tick):
  - dx=-1 and nx <= 48: hit if ny is within leftPaddle-29..leftPaddle+29 inclusive. On hit: x = 48, dx = +1. On miss: continue until nx <= 25, then right point.
  - dx=+1 and nx >= 592: hit if ny is within rightPaddle±29. On hit: x = 592, dx = -1. On miss: continue until nx >= 615, then left point.
  - Hit test uses the paddle value before this tick's paddle move.
- Point:
  - Ball goes to (320,220) and the state goes to POINT. The scorer increments in POINT.
  - Next serve dx points toward the player who conceded.
  - dy toggles on every serve.
- Scores saturate at 9 and never exceed 9.
- start outside GAME_OVER is ignored.

Decomposition:
- Package pong_pkg holds:
  - field and paddle geometry constants (20, 420, 620, 43, 597, 25, ball radius 4);
  - derived clamp limits (46, 394, 25, 415, 48, 592, 615);
  - the 2-bit state encoding SERVE/PLAY/POINT/GAME_OVER.
- Sub-module paddle_ctrl, instantiated twice, covers one paddle: its button inputs, the move/clamp logic, the freeze enable and its centre register.

Test Plan:
- Reset, then 3 ticks with right_down=1 -> rightPaddle 220→232; leftPaddle stays 220; ball stays (320,220).
- left_up=1 for 50 ticks -> leftPaddle saturates at 46 and stays there. Both buttons pressed -> no movement.
- Reset, then 60 ticks -> PLAY begins. The next tick gives ball (322,222).
- Right paddle tracking ball.y -> ball reaches x=592, dx flips, x decreases by 2 per tick.
- Left paddle parked at 394 with the ball near y≈100 moving left -> left miss, scoreRight=1 after the POINT tick, ball (320,220), then SERVE with dx=-1.
- Force 9 right points -> game_over=1, scoreRight=9, paddles frozen. A tick with start=1 gives scores 0, paddles 220, state SERVE. Reset asserted mid-PLAY with frame_tick=1 returns all reset values.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared geometry, derived clamp limits, state encoding and small helpers
// for the per-frame Pong game datapath.
package pong_pkg;
  localparam logic [9:0] FIELD_TOP    = 10'd20;
  localparam logic [9:0] FIELD_BOTTOM = 10'd420;
  localparam logic [9:0] FIELD_LEFT   = 10'd20;
  localparam logic [9:0] FIELD_RIGHT  = 10'd620;
  localparam logic [9:0] LEFT_FACE    = 10'd43;
  localparam logic [9:0] RIGHT_FACE   = 10'd597;
  localparam logic [9:0] PADDLE_HALF  = 10'd25;
  localparam logic [9:0] BALL_RADIUS  = 10'd4;

  // Limits keep paddle and ball one pixel clear of the border or paddle face.
  localparam logic [9:0] PADDLE_MIN   = FIELD_TOP + PADDLE_HALF + 10'd1;
  localparam logic [9:0] PADDLE_MAX   = FIELD_BOTTOM - PADDLE_HALF - 10'd1;
  localparam logic [9:0] BALL_Y_MIN   = FIELD_TOP + BALL_RADIUS + 10'd1;
  localparam logic [9:0] BALL_Y_MAX   = FIELD_BOTTOM - BALL_RADIUS - 10'd1;
  localparam logic [9:0] BALL_X_HIT_L = LEFT_FACE + BALL_RADIUS + 10'd1;
  localparam logic [9:0] BALL_X_HIT_R = RIGHT_FACE - BALL_RADIUS - 10'd1;
  localparam logic [9:0] BALL_X_OUT_L = FIELD_LEFT + BALL_RADIUS + 10'd1;
  localparam logic [9:0] BALL_X_OUT_R = FIELD_RIGHT - BALL_RADIUS - 10'd1;
  localparam logic [9:0] HIT_REACH    = PADDLE_HALF + BALL_RADIUS;

  localparam logic [9:0] PADDLE_HOME  = 10'd220;
  localparam logic [9:0] BALL_HOME_X  = 10'd320;
  localparam logic [9:0] BALL_HOME_Y  = 10'd220;
  localparam logic [3:0] MAX_SCORE    = 4'd9;

  localparam logic [1:0] ST_SERVE     = 2'd0;
  localparam logic [1:0] ST_PLAY      = 2'd1;
  localparam logic [1:0] ST_POINT     = 2'd2;
  localparam logic [1:0] ST_GAME_OVER = 2'd3;

  function automatic logic in_reach(input logic [10:0] pos, input logic [9:0] centre);
    logic [10:0] c;
    logic [10:0] r;
    c = {1'b0, centre};
    r = {1'b0, HIT_REACH};
    return (pos + r >= c) && (pos <= c + r);
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= MAX_SCORE) ? MAX_SCORE : s + 4'd1;
  endfunction
endpackage

// File: rtl/paddle_ctrl.sv
// One paddle: button decode, saturating move, freeze/recentre and the centre register.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SPEED = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       up,
  input  logic       down,
  input  logic       freeze,
  input  logic       recentre,
  output logic [9:0] centre
);
  localparam logic [9:0] STEP = 10'(SPEED);

  always_ff @(posedge clk) begin
    if (reset) begin
      centre <= PADDLE_HOME;
    end else if (tick) begin
      if (recentre) begin
        centre <= PADDLE_HOME;
      end else if (!freeze) begin
        // Compare before stepping so the centre saturates instead of wrapping.
        if (up && !down)
          centre <= (centre <= PADDLE_MIN + STEP) ? PADDLE_MIN : centre - STEP;
        else if (down && !up)
          centre <= (centre >= PADDLE_MAX - STEP) ? PADDLE_MAX : centre + STEP;
      end
    end
  end
endmodule

// File: rtl/pong_game_state.sv
// Per-frame Pong game state: paddles, ball motion, scoring and the
// serve / play / point / game-over sequencing, advanced on frame_tick.
module pong_game_state
  import pong_pkg::*;
#(
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  input  logic       start,
  output logic [9:0] leftPaddle,
  output logic [9:0] rightPaddle,
  output logic [9:0] ball_center_x,
  output logic [9:0] ball_center_y,
  output logic [3:0] scoreLeft,
  output logic [3:0] scoreRight,
  output logic       game_over
);
  // state        | meaning
  // ST_SERVE     | ball parked at centre, serve counter running
  // ST_PLAY      | ball moving; walls, paddle hits and misses resolved per frame
  // ST_POINT     | single frame that credits the scorer
  // ST_GAME_OVER | a player reached WIN_SCORE; paddles frozen until start

  localparam logic [10:0] STEP       = 11'(BALL_SPEED);
  localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  logic [1:0]  state;
  logic [7:0]  serve_cnt;
  logic        dx_pos, dy_pos, right_scored;
  logic [10:0] nx, ny;
  logic        left_zone, right_zone, hit_left, hit_right, left_out, right_out;
  logic        freeze, recentre;
  logic [3:0]  score_next;

  assign game_over = (state == ST_GAME_OVER);
  assign freeze    = (state == ST_GAME_OVER);
  assign recentre  = (state == ST_GAME_OVER) && start;

  paddle_ctrl #(.SPEED(PADDLE_SPEED)) u_left (
    .clk(clk), .reset(reset), .tick(frame_tick), .up(left_up), .down(left_down),
    .freeze(freeze), .recentre(recentre), .centre(leftPaddle)
  );

  paddle_ctrl #(.SPEED(PADDLE_SPEED)) u_right (
    .clk(clk), .reset(reset), .tick(frame_tick), .up(right_up), .down(right_down),
    .freeze(freeze), .recentre(recentre), .centre(rightPaddle)
  );

  // Hit tests see the paddle registers before this frame's paddle move.
  always_comb begin
    nx = '0;
    ny = '0;
    if (dx_pos) nx = {1'b0, ball_center_x} + STEP;
    else if ({1'b0, ball_center_x} >= STEP) nx = {1'b0, ball_center_x} - STEP;
    if (dy_pos) ny = {1'b0, ball_center_y} + STEP;
    else if ({1'b0, ball_center_y} >= STEP) ny = {1'b0, ball_center_y} - STEP;
    hit_left   = in_reach(ny, leftPaddle);
    hit_right  = in_reach(ny, rightPaddle);
    left_zone  = !dx_pos && (nx <= {1'b0, BALL_X_HIT_L});
    right_zone = dx_pos && (nx >= {1'b0, BALL_X_HIT_R});
    left_out   = left_zone && !hit_left && (nx <= {1'b0, BALL_X_OUT_L});
    right_out  = right_zone && !hit_right && (nx >= {1'b0, BALL_X_OUT_R});
    score_next = right_scored ? sat_inc(scoreRight) : sat_inc(scoreLeft);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_SERVE;
      serve_cnt     <= '0;
      ball_center_x <= BALL_HOME_X;
      ball_center_y <= BALL_HOME_Y;
      dx_pos        <= 1'b1;
      dy_pos        <= 1'b1;
      right_scored  <= 1'b0;
      scoreLeft     <= '0;
      scoreRight    <= '0;
    end else if (frame_tick) begin
      case (state)
        ST_SERVE: begin
          ball_center_x <= BALL_HOME_X;
          ball_center_y <= BALL_HOME_Y;
          if (serve_cnt == SERVE_LAST) begin
            serve_cnt <= '0;
            state     <= ST_PLAY;
          end else begin
            serve_cnt <= serve_cnt + 8'd1;
          end
        end
        ST_PLAY: begin
          if (left_out || right_out) begin
            // Serve heads toward whoever conceded; vertical direction flips each serve.
            ball_center_x <= BALL_HOME_X;
            ball_center_y <= BALL_HOME_Y;
            dx_pos        <= right_out;
            dy_pos        <= ~dy_pos;
            right_scored  <= left_out;
            state         <= ST_POINT;
          end else begin
            if (ny <= {1'b0, BALL_Y_MIN}) begin
              ball_center_y <= BALL_Y_MIN;
              dy_pos        <= 1'b1;
            end else if (ny >= {1'b0, BALL_Y_MAX}) begin
              ball_center_y <= BALL_Y_MAX;
              dy_pos        <= 1'b0;
            end else begin
              ball_center_y <= ny[9:0];
            end
            if (left_zone && hit_left) begin
              ball_center_x <= BALL_X_HIT_L;
              dx_pos        <= 1'b1;
            end else if (right_zone && hit_right) begin
              ball_center_x <= BALL_X_HIT_R;
              dx_pos        <= 1'b0;
            end else begin
              ball_center_x <= nx[9:0];
            end
          end
        end
        ST_POINT: begin
          if (right_scored) scoreRight <= score_next;
          else scoreLeft <= score_next;
          state <= (score_next == WIN) ? ST_GAME_OVER : ST_SERVE;
        end
        ST_GAME_OVER: begin
          ball_center_x <= BALL_HOME_X;
          ball_center_y <= BALL_HOME_Y;
          if (start) begin
            scoreLeft  <= '0;
            scoreRight <= '0;
            state      <= ST_SERVE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pong_game_state.sv
// Randomised, self-checking bench for pong_game_state against a frame-level game model.
module tb_pong_game_state;
  localparam int PADDLE_SPEED = 4;
  localparam int BALL_SPEED   = 2;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE    = 9;

  logic clk = 1'b0;
  logic reset = 1'b1, frame_tick = 1'b0, start = 1'b0;
  logic left_up = 1'b0, left_down = 1'b0, right_up = 1'b0, right_down = 1'b0;
  logic [9:0] leftPaddle, rightPaddle, ball_center_x, ball_center_y;
  logic [3:0] scoreLeft, scoreRight;
  logic       game_over;
  logic [48:0] observed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pong_game_state #(
    .PADDLE_SPEED(PADDLE_SPEED), .BALL_SPEED(BALL_SPEED),
    .SERVE_FRAMES(SERVE_FRAMES), .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .left_up(left_up), .left_down(left_down), .right_up(right_up), .right_down(right_down),
    .start(start), .leftPaddle(leftPaddle), .rightPaddle(rightPaddle),
    .ball_center_x(ball_center_x), .ball_center_y(ball_center_y),
    .scoreLeft(scoreLeft), .scoreRight(scoreRight), .game_over(game_over)
  );

  assign observed = {leftPaddle, rightPaddle, ball_center_x, ball_center_y,
                     scoreLeft, scoreRight, game_over};

  // Frame-level game model: plain integers, one call per frame.
  typedef enum {WAITING, RALLY, SCORED, FINISHED} phase_t;
  phase_t m_ph;
  int m_lp, m_rp, m_bx, m_by, m_vx, m_vy, m_sl, m_sr, m_cnt;
  bit m_right_pt;

  function automatic void model_reset();
    m_ph = WAITING; m_lp = 220; m_rp = 220; m_bx = 320; m_by = 220;
    m_vx = 1; m_vy = 1; m_sl = 0; m_sr = 0; m_cnt = 0; m_right_pt = 0;
  endfunction

  function automatic int move_paddle(input int c, input bit u, input bit d);
    if (u && !d) return (c - PADDLE_SPEED < 46) ? 46 : c - PADDLE_SPEED;
    if (d && !u) return (c + PADDLE_SPEED > 394) ? 394 : c + PADDLE_SPEED;
    return c;
  endfunction

  function automatic void model_tick(input bit lu, input bit ld, input bit ru,
                                     input bit rd, input bit st);
    int old_lp, old_rp, old_vy, nx, ny;
    old_lp = m_lp; old_rp = m_rp; old_vy = m_vy;
    if (m_ph != FINISHED) begin
      m_lp = move_paddle(m_lp, lu, ld);
      m_rp = move_paddle(m_rp, ru, rd);
    end
    case (m_ph)
      WAITING: begin
        if (m_cnt == SERVE_FRAMES - 1) begin m_cnt = 0; m_ph = RALLY; end
        else m_cnt++;
      end
      RALLY: begin
        nx = m_bx + BALL_SPEED * m_vx; if (nx < 0) nx = 0;
        ny = m_by + BALL_SPEED * m_vy; if (ny < 0) ny = 0;
        if (ny <= 25) begin m_by = 25; m_vy = 1; end
        else if (ny >= 415) begin m_by = 415; m_vy = -1; end
        else m_by = ny;
        if (m_vx < 0 && nx <= 48 && ny >= old_lp - 29 && ny <= old_lp + 29) begin
          m_bx = 48; m_vx = 1;
        end else if (m_vx > 0 && nx >= 592 && ny >= old_rp - 29 && ny <= old_rp + 29) begin
          m_bx = 592; m_vx = -1;
        end else m_bx = nx;
        if (m_bx <= 25 || m_bx >= 615) begin
          m_right_pt = (m_bx <= 25);
          m_vx = m_right_pt ? -1 : 1;
          m_vy = -old_vy;
          m_bx = 320; m_by = 220;
          m_ph = SCORED;
        end
      end
      SCORED: begin
        if (m_right_pt) m_sr = (m_sr >= 9) ? 9 : m_sr + 1;
        else m_sl = (m_sl >= 9) ? 9 : m_sl + 1;
        m_ph = ((m_right_pt ? m_sr : m_sl) == WIN_SCORE) ? FINISHED : WAITING;
      end
      FINISHED: begin
        if (st) begin
          m_sl = 0; m_sr = 0; m_lp = 220; m_rp = 220; m_ph = WAITING;
        end
      end
    endcase
  endfunction

  function automatic logic [48:0] model_vec();
    return {10'(m_lp), 10'(m_rp), 10'(m_bx), 10'(m_by), 4'(m_sl), 4'(m_sr),
            (m_ph == FINISHED)};
  endfunction

  function automatic string show(input logic [48:0] v);
    return $sformatf("lp=%0d rp=%0d bx=%0d by=%0d sl=%0d sr=%0d go=%0d",
                     v[48:39], v[38:29], v[28:19], v[18:9], v[8:5], v[4:1], v[0]);
  endfunction

  // One frame: pulse frame_tick with the given buttons, then idle cycles with noise.
  task automatic step(input bit lu, input bit ld, input bit ru, input bit rd, input bit st);
    @(negedge clk);
    left_up = lu; left_down = ld; right_up = ru; right_down = rd; start = st;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick(lu, ld, ru, rd, st);
    repeat ($urandom_range(0, 2)) begin
      {left_up, left_down, right_up, right_down, start} = 5'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'($urandom);
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (observed !== {10'd220, 10'd220, 10'd320, 10'd220, 4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %s want lp=220 rp=220 bx=320 by=220 sl=0 sr=0 go=0",
               show(observed));
    end
  endtask

  task automatic test_paddle_move();
    do_reset();
    repeat (3) step(0, 0, 0, 1, 0);
    checks++;
    if ({rightPaddle, leftPaddle, ball_center_x, ball_center_y} !==
        {10'd232, 10'd220, 10'd320, 10'd220}) begin
      errors++;
      $display("FAIL paddle_move: got rp=%0d lp=%0d ball=(%0d,%0d) want rp=232 lp=220 ball=(320,220)",
               rightPaddle, leftPaddle, ball_center_x, ball_center_y);
    end
  endtask

  task automatic test_paddle_clamp();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      step(1, 0, 0, 0, 0);
      checks++;
      if (observed !== model_vec()) begin
        errors++;
        $display("FAIL clamp step %0d: got %s want %s", i, show(observed), show(model_vec()));
      end
    end
    checks++;
    if (leftPaddle !== 10'd46) begin
      errors++;
      $display("FAIL clamp_min: got lp=%0d want 46", leftPaddle);
    end
    repeat (4) step(1, 1, 1, 1, 0);
    checks++;
    if ({leftPaddle, rightPaddle} !== {10'd46, 10'd220}) begin
      errors++;
      $display("FAIL both_buttons: got lp=%0d rp=%0d want lp=46 rp=220", leftPaddle, rightPaddle);
    end
  endtask

  task automatic test_serve_launch();
    do_reset();
    for (int i = 0; i < SERVE_FRAMES; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if ({ball_center_x, ball_center_y} !== {10'd320, 10'd220}) begin
        errors++;
        $display("FAIL serve_hold tick %0d: got ball=(%0d,%0d) want (320,220)",
                 i, ball_center_x, ball_center_y);
      end
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if ({ball_center_x, ball_center_y} !== {10'd322, 10'd222}) begin
      errors++;
      $display("FAIL serve_launch: got ball=(%0d,%0d) want (322,222)", ball_center_x, ball_center_y);
    end
  endtask

  task automatic test_right_bounce();
    bit found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(0, 0, m_rp > m_by, m_rp < m_by, 0);
      checks++;
      if (observed !== model_vec()) begin
        errors++;
        $display("FAIL right_bounce step %0d: got %s want %s", i, show(observed), show(model_vec()));
      end
      if (ball_center_x == 10'd592) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL right_bounce_reach: got bx=%0d after 300 ticks want 592", ball_center_x);
    end else begin
      step(0, 0, m_rp > m_by, m_rp < m_by, 0);
      checks++;
      if (ball_center_x !== 10'd590) begin
        errors++;
        $display("FAIL right_bounce_turn: got bx=%0d want 590", ball_center_x);
      end
      step(0, 0, m_rp > m_by, m_rp < m_by, 0);
      checks++;
      if (ball_center_x !== 10'd588) begin
        errors++;
        $display("FAIL right_bounce_turn2: got bx=%0d want 588", ball_center_x);
      end
    end
  endtask

  task automatic test_left_miss();
    bit found;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(0, 1, m_rp > m_by, m_rp < m_by, 0);
      checks++;
      if (observed !== model_vec()) begin
        errors++;
        $display("FAIL left_miss step %0d: got %s want %s", i, show(observed), show(model_vec()));
      end
      if (scoreRight == 4'd1) found = 1;
    end
    checks++;
    if (!found || {leftPaddle, ball_center_x, ball_center_y, scoreLeft} !==
                  {10'd394, 10'd320, 10'd220, 4'd0}) begin
      errors++;
      $display("FAIL left_miss_point: got sr=%0d lp=%0d ball=(%0d,%0d) sl=%0d want sr=1 lp=394 ball=(320,220) sl=0",
               scoreRight, leftPaddle, ball_center_x, ball_center_y, scoreLeft);
    end
    repeat (SERVE_FRAMES + 1) step(0, 1, 0, 0, 0);
    checks++;
    if (ball_center_x !== 10'd318) begin
      errors++;
      $display("FAIL serve_toward_conceder: got bx=%0d want 318", ball_center_x);
    end
  endtask

  task automatic test_game_over();
    bit found;
    found = 0;
    for (int i = 0; i < 3000 && !found; i++) begin
      step(0, 1, m_rp > m_by, m_rp < m_by, 0);
      checks++;
      if (observed !== model_vec()) begin
        errors++;
        $display("FAIL game_over step %0d: got %s want %s", i, show(observed), show(model_vec()));
      end
      if (game_over === 1'b1) found = 1;
    end
    checks++;
    if (!found || {scoreRight, scoreLeft} !== {4'd9, 4'd0}) begin
      errors++;
      $display("FAIL game_over_reach: got go=%0d sr=%0d sl=%0d want go=1 sr=9 sl=0",
               game_over, scoreRight, scoreLeft);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
      checks++;
      if (observed !== model_vec() || leftPaddle !== 10'd394 || game_over !== 1'b1) begin
        errors++;
        $display("FAIL frozen step %0d: got %s want %s", i, show(observed), show(model_vec()));
      end
    end
    step(1, 0, 0, 1, 1);
    checks++;
    if ({leftPaddle, rightPaddle, scoreLeft, scoreRight, game_over} !==
        {10'd220, 10'd220, 4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL restart: got %s want lp=220 rp=220 sl=0 sr=0 go=0", show(observed));
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (observed !== model_vec() || {ball_center_x, ball_center_y} !== {10'd320, 10'd220}) begin
      errors++;
      $display("FAIL restart_serve: got %s want %s", show(observed), show(model_vec()));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      checks++;
      if (observed !== model_vec()) begin
        errors++;
        $display("FAIL random step %0d: got %s want %s", i, show(observed), show(model_vec()));
      end
    end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    repeat (SERVE_FRAMES + 15) step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b1;
    {left_up, left_down, right_up, right_down} = 4'b0101;
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b0;
    model_reset();
    checks++;
    if (observed !== {10'd220, 10'd220, 10'd320, 10'd220, 4'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_play: got %s want lp=220 rp=220 bx=320 by=220 sl=0 sr=0 go=0",
               show(observed));
    end
    step(0, 0, 0, 0, 0);
    checks++;
    if (observed !== model_vec()) begin
      errors++;
      $display("FAIL after_reset: got %s want %s", show(observed), show(model_vec()));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_paddle_move();
    test_paddle_clamp();
    test_serve_launch();
    test_right_bounce();
    test_left_miss();
    test_game_over();
    test_random();
    test_reset_mid_play();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
